// File: rtl/seg_scan_ctrl.sv
// Three-digit 7-segment scan controller: captures digit patterns once per frame
// and time-multiplexes them onto a shared segment bus with a blank gap before each slot.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16,
  parameter bit SEG_INV   = 1'b0,
  parameter bit DIG_INV   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lzb,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  output logic [7:0] seg_out,
  output logic [2:0] dig_sel,
  output logic       frame_done
);
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [7:0]    SEG_OFF    = SEG_INV ? 8'hFF : 8'h00;
  localparam logic [2:0]    DIG_OFF    = DIG_INV ? 3'b111 : 3'b000;
  localparam logic [7:0]    ZERO_PAT   = 8'h3F;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      slot_q;
  logic [7:0]      sh0_q, sh1_q, sh2_q;
  logic [7:0]      seg_out_q;
  logic [2:0]      dig_sel_q;
  logic            frame_done_q;

  logic            blank2, blank1, blank_cur;
  logic [7:0]      pat;
  logic [7:0]      show_seg;
  logic [2:0]      show_dig;

  // Displayed value for the current slot; lzb is live, shadows are frame-stable.
  always_comb begin
    blank2 = lzb && (sh2_q == ZERO_PAT);
    blank1 = blank2 && (sh1_q == ZERO_PAT);
    case (slot_q)
      2'd1:    begin pat = sh1_q; blank_cur = blank1; end
      2'd2:    begin pat = sh2_q; blank_cur = blank2; end
      default: begin pat = sh0_q; blank_cur = 1'b0;   end
    endcase
    show_seg = (blank_cur ? 8'h00 : pat) ^ {8{SEG_INV}};
    show_dig = (3'b001 << slot_q) ^ {3{DIG_INV}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      slot_q       <= 2'd0;
      sh0_q        <= 8'h00;
      sh1_q        <= 8'h00;
      sh2_q        <= 8'h00;
      seg_out_q    <= SEG_OFF;
      dig_sel_q    <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (!en) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        slot_q    <= 2'd0;
        seg_out_q <= SEG_OFF;
        dig_sel_q <= DIG_OFF;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            slot_q    <= 2'd0;
            sh0_q     <= seg0;
            sh1_q     <= seg1;
            sh2_q     <= seg2;
            seg_out_q <= SEG_OFF;
            dig_sel_q <= DIG_OFF;
          end
          BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              state_q   <= SHOW;
              cnt_q     <= '0;
              seg_out_q <= show_seg;
              dig_sel_q <= show_dig;
            end else begin
              cnt_q     <= cnt_q + 1'b1;
              seg_out_q <= SEG_OFF;
              dig_sel_q <= DIG_OFF;
            end
          end
          SHOW: begin
            if (cnt_q == SHOW_LAST) begin
              state_q   <= BLANK;
              cnt_q     <= '0;
              seg_out_q <= SEG_OFF;
              dig_sel_q <= DIG_OFF;
              // Frame wrap: recapture inputs so the next frame is tear-free.
              if (slot_q == 2'd2) begin
                slot_q       <= 2'd0;
                sh0_q        <= seg0;
                sh1_q        <= seg1;
                sh2_q        <= seg2;
                frame_done_q <= 1'b1;
              end else begin
                slot_q <= slot_q + 2'd1;
              end
            end else begin
              cnt_q     <= cnt_q + 1'b1;
              seg_out_q <= show_seg;
              dig_sel_q <= show_dig;
            end
          end
          default: begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            slot_q    <= 2'd0;
            seg_out_q <= SEG_OFF;
            dig_sel_q <= DIG_OFF;
          end
        endcase
      end
    end
  end

  assign seg_out    = seg_out_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: normal and inverted-polarity instances checked every
// cycle against a frame-position model of the scan sequence.
module tb_seg_scan_ctrl;
  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst, en, lzb;
  logic [7:0] seg0, seg1, seg2;
  logic [7:0] so_n, so_i;
  logic [2:0] ds_n, ds_i;
  logic       fd_n, fd_i;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_INV(1'b0), .DIG_INV(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .lzb(lzb), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .seg_out(so_n), .dig_sel(ds_n), .frame_done(fd_n));

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_INV(1'b1), .DIG_INV(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .en(en), .lzb(lzb), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .seg_out(so_i), .dig_sel(ds_i), .frame_done(fd_i));

  int checks = 0;
  int failures = 0;

  // Model: whether scanning, position within the 3*SD-cycle frame, captured digits.
  bit         m_act;
  int         m_pos;
  logic [7:0] m_sh [3];
  logic [7:0] e_seg;
  logic [2:0] e_dig;
  logic       e_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    m_act = 1'b0;
    m_pos = 0;
    m_sh  = '{default: 8'h00};
  endtask

  task automatic mdl_out();
    int  s, k;
    bit  blank;
    s = m_pos / SD;
    k = m_pos % SD;
    e_seg = 8'h00;
    e_dig = 3'b000;
    if (m_act && k >= BC) begin
      e_dig = 3'(1 << s);
      blank = lzb && (m_sh[2] == 8'h3F) && (s == 2 || (s == 1 && m_sh[1] == 8'h3F));
      e_seg = blank ? 8'h00 : m_sh[s];
    end
  endtask

  task automatic mdl_capture();
    m_sh[0] = seg0;
    m_sh[1] = seg1;
    m_sh[2] = seg2;
  endtask

  task automatic mdl_edge();
    e_fd = 1'b0;
    if (rst) mdl_clear();
    else if (!en) begin
      m_act = 1'b0;
      m_pos = 0;
    end else if (!m_act) begin
      m_act = 1'b1;
      m_pos = 0;
      mdl_capture();
    end else begin
      m_pos++;
      if (m_pos == 3 * SD) begin
        m_pos = 0;
        mdl_capture();
        e_fd = 1'b1;
      end
    end
    mdl_out();
  endtask

  task automatic cmp_all();
    logic [7:0] ns;
    logic [2:0] nd;
    ns = ~e_seg;
    nd = ~e_dig;
    chk("seg_out", so_n, e_seg);
    chk("dig_sel", ds_n, e_dig);
    chk("frame_done", fd_n, e_fd);
    chk("seg_out_inv", so_i, ns);
    chk("dig_sel_inv", ds_i, nd);
    chk("frame_done_inv", fd_i, e_fd);
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl_edge();
    #1;
    cmp_all();
  endtask

  // Reset pulse between edges; outputs must clear without a clock edge.
  task automatic async_rst();
    #2 rst = 1'b1;
    #1;
    mdl_clear();
    e_seg = 8'h00;
    e_dig = 3'b000;
    e_fd  = 1'b0;
    cmp_all();
    #1 rst = 1'b0;
  endtask

  task automatic wait_show(input int s);
    int n;
    n = 0;
    while (!(m_act && m_pos / SD == s && m_pos % SD >= BC + 1) && n < 200) begin
      cyc();
      n++;
    end
    chk("wait_show_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic restart(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    en = 1'b0;
    cyc();
    seg0 = a;
    seg1 = b;
    seg2 = c;
    en = 1'b1;
    repeat (3 * SD + 3) cyc();
  endtask

  function automatic logic [7:0] rnd_pat();
    case ($urandom_range(0, 3))
      0, 1:    rnd_pat = 8'h3F;
      2:       rnd_pat = 8'hBF;
      default: rnd_pat = 8'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; lzb = 1'b0;
    seg0 = 8'h00; seg1 = 8'h00; seg2 = 8'h00;
    mdl_clear();
    e_seg = 8'h00; e_dig = 3'b000; e_fd = 1'b0;
    #1 cmp_all();
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // Basic scan, with a mid-frame change to seg1 that must wait a frame.
    seg0 = 8'h06; seg1 = 8'h5B; seg2 = 8'h4F; en = 1'b1;
    repeat (5) cyc();
    seg1 = 8'h66;
    repeat (3 * 3 * SD) cyc();

    // Leading-zero blanking cases.
    lzb = 1'b1;
    restart(8'h3F, 8'h3F, 8'h3F);
    restart(8'h3F, 8'h06, 8'h3F);
    restart(8'h3F, 8'h3F, 8'hBF);
    restart(8'h5B, 8'h3F, 8'h3F);
    lzb = 1'b0;
    restart(8'h3F, 8'h3F, 8'h3F);

    // Drop en during slot 1 SHOW, then restart with new inputs.
    wait_show(1);
    en = 1'b0;
    repeat (3) cyc();
    seg0 = 8'h7D; seg1 = 8'h07; seg2 = 8'h7F;
    en = 1'b1;
    repeat (3 * SD + 2) cyc();

    // Async reset mid-SHOW, then stay off until en returns.
    wait_show(2);
    en = 1'b0;
    async_rst();
    repeat (4) cyc();
    en = 1'b1;
    repeat (3 * SD + 2) cyc();

    // Randomized run.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       seg0 = rnd_pat();
          1:       seg1 = rnd_pat();
          default: seg2 = rnd_pat();
        endcase
      end
      if ($urandom_range(0, 15) == 0) lzb = 1'($urandom);
      en = ($urandom_range(0, 79) != 0);
      cyc();
      if ($urandom_range(0, 299) == 0) async_rst();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
